// File: rtl/float_divider.sv
// Sequential restoring floating-point divider (a / b), one quotient bit per cycle,
// truncating result, with start/busy/done handshake and FPU status flags.
module float_divider #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact,
  output logic                  zero,
  output logic                  div_by_zero
);

  localparam int N  = MANTISSA_SIZE + 2;
  localparam int CW = $clog2(N + 1);
  localparam int EW = EXPONENT_SIZE + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_NORM   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXPONENT_SIZE) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  logic [1:0]             state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [N-1:0]           rem_q, rem_d;
  logic [N-1:0]           dvs_q, dvs_d;
  logic [N-1:0]           quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   bz_q, bz_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [FLOAT_SIZE-1:0]  out_q, out_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   inx_q, inx_d;
  logic                   zero_q, zero_d;
  logic                   dbz_q, dbz_d;

  logic                   ge_s;
  logic [N-1:0]           diff_s;
  logic signed [EW-1:0]   exp_adj_s;
  logic [MANTISSA_SIZE-1:0] man_s;
  logic                   inx_s;
  logic [EXPONENT_SIZE-1:0] ea_s, eb_s;

  // Next-state logic: handshake, restoring iteration, normalization and range checks
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    bz_d      = bz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    out_d     = out_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inx_d     = inx_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    ea_s      = a[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    eb_s      = b[FLOAT_SIZE-2 -: EXPONENT_SIZE];
    ge_s      = (rem_q >= dvs_q);
    diff_s    = ge_s ? (rem_q - dvs_q) : rem_q;
    exp_adj_s = exp_q;
    man_s     = quo_q[N-2:1];
    inx_s     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
          exp_d  = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + EW'(BIAS);
          rem_d  = {1'b0, 1'b1, a[MANTISSA_SIZE-1:0]};
          dvs_d  = {1'b0, 1'b1, b[MANTISSA_SIZE-1:0]};
          quo_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          bz_d   = (eb_s == '0);
          // Zero operands bypass the iteration entirely
          if ((eb_s == '0) || (ea_s == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DIVIDE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIVIDE: begin
        quo_d = {quo_q[N-2:0], ge_s};
        rem_d = diff_s << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_NORM;
        end else begin
          state_d = S_DIVIDE;
        end
      end
      S_NORM: begin
        if (quo_q[N-1]) begin
          man_s     = quo_q[N-2:1];
          exp_adj_s = exp_q;
          inx_s     = quo_q[0] | (|rem_q);
        end else begin
          man_s     = quo_q[N-3:0];
          exp_adj_s = exp_q - EXP_ONE;
          inx_s     = |rem_q;
        end
        dbz_d = 1'b0;
        if (exp_adj_s >= EXP_MAX) begin
          out_d  = {sign_q, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
          ovf_d  = 1'b1;
          unf_d  = 1'b0;
          inx_d  = 1'b1;
          zero_d = 1'b0;
        end else if (exp_adj_s <= EXP_ZERO) begin
          out_d  = {sign_q, {EXPONENT_SIZE{1'b0}}, {MANTISSA_SIZE{1'b0}}};
          ovf_d  = 1'b0;
          unf_d  = 1'b1;
          inx_d  = 1'b1;
          zero_d = 1'b1;
        end else begin
          out_d  = {sign_q, exp_adj_s[EXPONENT_SIZE-1:0], man_s};
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          inx_d  = inx_s;
          zero_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Arrival with done low means a special operand still needs its result
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          inx_d  = 1'b0;
          done_d = 1'b1;
          if (bz_q) begin
            out_d  = {sign_q, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
            zero_d = 1'b0;
            dbz_d  = 1'b1;
          end else begin
            out_d  = {sign_q, {EXPONENT_SIZE{1'b0}}, {MANTISSA_SIZE{1'b0}}};
            zero_d = 1'b1;
            dbz_d  = 1'b0;
          end
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      bz_q    <= bz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out         = out_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign inexact     = inx_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_float_divider.sv
// Self-checking bench for float_divider: directed cases, handshake/reset cases and
// randomized operands against an integer-arithmetic reference model.
module tb_float_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] out;
  logic        overflow, underflow, inexact, zero, div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  float_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out),
    .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .zero(zero), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Result vector layout: {out, overflow, underflow, inexact, zero, div_by_zero}
  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, e;
    longint      num, den, q, r;
    logic [22:0] mant;
    logic        inx;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ey == 0) return {s, 8'hFF, 23'h0, 5'b00001};
    if (ex == 0) return {s, 31'h0, 5'b00010};
    num = longint'({1'b1, x[22:0]}) << 24;
    den = longint'({1'b1, y[22:0]});
    q   = num / den;
    r   = num % den;
    e   = ex - ey + 127;
    if (q >= (64'sd1 <<< 24)) begin
      mant = 23'((q >> 1) & 64'h7FFFFF);
      inx  = ((q & 64'sd1) != 64'sd0) || (r != 64'sd0);
    end else begin
      mant = 23'(q & 64'h7FFFFF);
      e    = e - 1;
      inx  = (r != 64'sd0);
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 5'b10100};
    if (e <= 0)   return {s, 31'h0, 5'b01110};
    return {s, 8'(e), mant, 2'b00, inx, 2'b00};
  endfunction

  function automatic logic [36:0] dut_res();
    return {out, overflow, underflow, inexact, zero, div_by_zero};
  endfunction

  // Launches one operation; optionally pulses a second start with other operands mid-run
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [36:0] expv, input int exp_lat, input int inject_at);
    int cyc;
    int busy_bad;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    busy_bad = (busy !== 1'b1) ? 1 : 0;
    while (cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) break;
      if (cyc == inject_at) begin
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_res"}, 64'(dut_res()), 64'(expv));
    @(posedge clk); #1;
    check({tag, "_end"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    int          done_seen;
    rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {25'd0, busy, done, dut_res()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("6div2",   32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000}, 26, 0);
    run_op("1div3",   32'h3F800000, 32'h40400000, {32'h3EAAAAAA, 5'b00100}, 26, 0);
    run_op("neg1div0",32'hBF800000, 32'h00000000, {32'hFF800000, 5'b00001}, 1, 0);
    run_op("0div2",   32'h00000000, 32'h40000000, {32'h00000000, 5'b00010}, 1, 0);
    run_op("0div0",   32'h00000000, 32'h00000000, {32'h7F800000, 5'b00001}, 1, 0);
    run_op("ovf",     32'h7F000000, 32'h3E800000, {32'h7F800000, 5'b10100}, 26, 0);
    run_op("unf",     32'h00800000, 32'h40000000, {32'h00000000, 5'b01110}, 26, 0);
    run_op("ignore",  32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000}, 26, 5);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset", {25'd0, busy, done, dut_res()}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    check("no_done_after_reset", 64'(done_seen), 64'd0);
    run_op("6div2_again", 32'h40C00000, 32'h40000000, {32'h40400000, 5'b00000}, 26, 0);

    // Randomized operands, occasionally with a zero field
    for (int i = 0; i < 40; i++) begin
      x = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
      y = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
      if ($urandom_range(9, 0) == 0) x[30:23] = 8'h00;
      if ($urandom_range(9, 0) == 0) y[30:23] = 8'h00;
      run_op($sformatf("rnd%0d", i), x, y, model(x, y),
             ((x[30:23] == 8'h00) || (y[30:23] == 8'h00)) ? 1 : 26, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/float_divider.md
# float_divider

Sequential floating-point divider computing `a / b` for two normalized floats using restoring division, one quotient bit per cycle. It is the inverse-direction companion of the float multiplier in the FPU datapath and shares its parameterization and status-flag set. A start/busy/done handshake launches each operation; the result is truncated (round toward zero).

## Interface
- `FLOAT_SIZE`, 32: total float width.
- `EXPONENT_SIZE`, 8: exponent field width.
- `MANTISSA_SIZE`, 23: stored mantissa width (hidden 1 implied).
- `BIAS`, 127: exponent bias.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `a` in FLOAT_SIZE: dividend, format {S, E, M}.
- `b` in FLOAT_SIZE: divisor.
- `busy` out 1: an operation is in progress.
- `done` out 1: one-cycle pulse; result and flags valid.
- `out` out FLOAT_SIZE: quotient.
- `overflow` out 1: result exponent too large.
- `underflow` out 1: result exponent too small.
- `inexact` out 1: nonzero bits were discarded.
- `zero` out 1: result is zero.
- `div_by_zero` out 1: `b` is zero.

## Operation
- Exponent field 0 denotes zero; no denormals. All-ones exponent inputs are unsupported, so the result for them is unspecified.
- States:
  - IDLE: waits for `start`.
  - DIVIDE: runs N = MANTISSA_SIZE+2 iterations.
  - NORMALIZE: one cycle.
  - DONE: one cycle, then back to IDLE.
- On accepted `start`, the block latches the sign as `sign_a ^ sign_b`.
- The biased exponent is computed as `e_a - e_b + BIAS` in EXPONENT_SIZE+2-bit signed arithmetic.
- Division setup:
  - Remainder R = {1, m_a}; divisor D = {1, m_b}; both MANTISSA_SIZE+2 bits wide.
  - Iteration counter is cleared.
- Each DIVIDE cycle:
  - If R ≥ D, the quotient bit is 1 and R ← R − D; otherwise the quotient bit is 0.
  - Shift the bit into the quotient LSB, then R ← R << 1.
  - The first quotient bit has weight 2^0.
- NORMALIZE:
  - If q[N-1]=1: mantissa = q[N-2:1] and inexact = q[0] | (R≠0).
  - Otherwise: mantissa = q[N-3:0], exponent −= 1, and inexact = (R≠0).
- Range checks on the final exponent:
  - Final exponent ≥ 2^EXPONENT_SIZE−1: `out` = {sign, all-ones, 0}, with `overflow`=1 and `inexact`=1.
  - Final exponent ≤ 0: `out` = {sign, 0, 0}, with `underflow`=1, `zero`=1 and `inexact`=1.
- Special operands skip DIVIDE and NORMALIZE and go from IDLE directly to DONE:
  - `b` zero: `div_by_zero`=1 and `out` = {sign, all-ones, 0}, whatever `a` is (this also covers 0/0). All other flags are 0.
  - Otherwise, `a` zero: `out` = {sign, 0, 0} and `zero`=1. All other flags are 0.
- `start` while `busy`=1 is ignored. Operands are sampled only at acceptance, so changes to `a`/`b` during an operation have no effect.

## Timing
- Reset values (`rst_n`=0 at an edge): state IDLE, and `out`, all flags, `busy` and `done` are 0.
- Reset asserted mid-operation aborts the operation at that edge; no `done` follows.
- `start` accepted at edge 0:
  - `busy`=1 from edge 0 until the edge that enters IDLE.
  - DIVIDE occupies edges 1..N and NORMALIZE evaluates at edge N+1.
  - `out`/flags register and `done`=1 after edge N+1.
  - Latency is N+1 cycles (26 for single precision).
- Special operands: `out`/flags register and `done`=1 after edge 1 (latency 1).
- `done` is high for exactly one cycle. `busy` drops together with `done` falling.
- A new `start` is accepted in the cycle after `done`.
- `out` and flags hold their last values until the next `done`; they do not clear on `start`.

## Test plan
- 6.0 (0x40C00000) / 2.0 (0x40000000) → `out`=0x40400000 with all flags 0; `done` 26 cycles after `start`; `busy` high throughout.
- 1.0 (0x3F800000) / 3.0 (0x40400000) → `out`=0x3EAAAAAA and `inexact`=1 (normalization-shift path).
- -1.0 (0xBF800000) / 0x00000000 → `out`=0xFF800000 and `div_by_zero`=1, with `done` one cycle after `start`. Likewise 0x00000000 / 0x40000000 → `out`=0x00000000 and `zero`=1.
- Overflow: 0x7F000000 / 0x3E800000 (0.25) → `out`=0x7F800000 with `overflow`=1 and `inexact`=1.
- Underflow: 0x00800000 / 0x40000000 → `out`=0x00000000 with `underflow`=1, `zero`=1 and `inexact`=1.
- Busy and reset:
  - Pulse `start` with new operands 5 cycles into an operation → ignored, and the original result is returned.
  - Drive `rst_n`=0 10 cycles into an operation → next edge gives `busy`=0 and all outputs 0, and `done` never pulses.
  - A following 6.0/2.0 run completes normally.
